axilite_bk_arbiter: RTL and testbench



---
 rtl/axilite_arb_pkg.sv | 29 ++
 rtl/axilite_bk_arbiter_rr_pick.sv | 40 ++++
 rtl/axilite_bk_arbiter.sv | 156 +++++++++++++++
 tb/tb_axilite_bk_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axilite_arb_pkg.sv
// ============================================================================
// axilite_arb_pkg : shared types and helpers for the AXI-Lite backend arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

package axilite_arb_pkg;

  localparam int NUM_REQ_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_e;

  function automatic int clog2(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/axilite_bk_arbiter_rr_pick.sv
// ============================================================================
// rr_pick : combinational round-robin picker (valid + pointer -> one-hot + index)
// Revision: 1.0
// ============================================================================
`default_nettype none

module rr_pick
  import axilite_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEFAULT,
  parameter int IDX_W   = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);

  logic [IDX_W-1:0] w_cand;

  // Scan upward from the pointer; the first valid candidate wins.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = IDX_W'((int'(i_ptr) + k) % NUM_REQ);
      if (!o_any && i_valid[w_cand]) begin
        o_any           = 1'b1;
        o_idx           = w_cand;
        o_grant[w_cand] = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/axilite_bk_arbiter.sv
// ============================================================================
// axilite_bk_arbiter : round-robin arbiter sharing one AXI-Lite master backend
// Revision: 1.0
// ============================================================================
`default_nettype none

module axilite_bk_arbiter
  import axilite_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEFAULT
) (
  input  logic                   axi_aclk,
  input  logic                   axi_aresetn,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ-1:0]     req_wr,
  input  logic [NUM_REQ*32-1:0]  req_addr,
  input  logic [NUM_REQ*32-1:0]  req_wdata,
  input  logic [NUM_REQ*4-1:0]   req_wstrb,
  output logic [NUM_REQ-1:0]     req_done,
  output logic [31:0]            req_rdata,
  output logic                   busy,
  output logic                   bk_wstart,
  output logic [31:0]            bk_waddr,
  output logic [31:0]            bk_wdata,
  output logic [3:0]             bk_wstrb,
  output logic                   bk_rstart,
  output logic [31:0]            bk_raddr,
  input  logic                   bk_wdone,
  input  logic                   bk_rdone,
  input  logic [31:0]            bk_rdata
);

  localparam int IDX_W = clog2(NUM_REQ);

  arb_state_e       r_state;
  arb_state_e       w_state_nxt;
  logic [IDX_W-1:0] r_rr_ptr;
  logic [IDX_W-1:0] r_grant_idx;
  logic             r_wr;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;
  logic [3:0]       r_wstrb;
  logic [31:0]      r_rdata;
  logic             r_bk_wstart;
  logic             r_bk_rstart;

  logic [NUM_REQ-1:0] w_pick_grant;
  logic [IDX_W-1:0]   w_pick_idx;
  logic               w_pick_any;
  logic               w_accept;
  logic               w_done_match;
  logic               w_owned;
  logic               w_sel_wr;
  logic [31:0]        w_sel_addr;
  logic [31:0]        w_sel_wdata;
  logic [3:0]         w_sel_wstrb;
  logic [IDX_W-1:0]   w_ptr_nxt;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .i_valid (req_valid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_pick_grant),
    .o_idx   (w_pick_idx),
    .o_any   (w_pick_any)
  );

  always_comb begin
    w_sel_wr    = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    w_sel_wstrb = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_pick_idx == IDX_W'(i)) begin
        w_sel_wr    = req_wr[i];
        w_sel_addr  = req_addr[32*i +: 32];
        w_sel_wdata = req_wdata[32*i +: 32];
        w_sel_wstrb = req_wstrb[4*i +: 4];
      end
    end
  end

  assign w_accept     = (r_state == ST_IDLE) && w_pick_any;
  assign w_done_match = r_wr ? bk_wdone : bk_rdone;
  assign w_ptr_nxt    = (r_grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : r_grant_idx + 1'b1;

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) r_state <= ST_IDLE;
    else              r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_pick_any)   w_state_nxt = ST_ISSUE;
      ST_ISSUE:                   w_state_nxt = ST_WAIT;
      ST_WAIT:  if (w_done_match) w_state_nxt = ST_DONE;
      ST_DONE:                    w_state_nxt = ST_IDLE;
      default:                    w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      r_rr_ptr    <= '0;
      r_grant_idx <= '0;
      r_wr        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_rdata     <= '0;
      r_bk_wstart <= 1'b0;
      r_bk_rstart <= 1'b0;
    end else begin
      r_bk_wstart <= 1'b0;
      r_bk_rstart <= 1'b0;
      if (w_accept) begin
        r_grant_idx <= w_pick_idx;
        r_wr        <= w_sel_wr;
        r_addr      <= w_sel_addr;
        r_wdata     <= w_sel_wdata;
        r_wstrb     <= w_sel_wstrb;
        r_rdata     <= '0;
        r_bk_wstart <= w_sel_wr;
        r_bk_rstart <= ~w_sel_wr;
      end
      // Only a read completion carries data; stray pulses are ignored.
      if ((r_state == ST_WAIT) && !r_wr && bk_rdone) r_rdata <= bk_rdata;
      if (r_state == ST_DONE) r_rr_ptr <= w_ptr_nxt;
    end
  end

  assign w_owned   = (r_state != ST_IDLE);
  assign busy      = w_owned;
  assign bk_wstart = r_bk_wstart;
  assign bk_rstart = r_bk_rstart;
  assign bk_waddr  = w_owned ? r_addr  : '0;
  assign bk_wdata  = w_owned ? r_wdata : '0;
  assign bk_wstrb  = w_owned ? r_wstrb : '0;
  assign bk_raddr  = w_owned ? r_addr  : '0;

  // Ready is combinational from req_valid, so it must also be held off during reset.
  assign req_ready = (axi_aresetn && (r_state == ST_IDLE)) ? w_pick_grant : '0;
  assign req_rdata = ((r_state == ST_DONE) && !r_wr) ? r_rdata : '0;

  always_comb begin
    req_done = '0;
    if (r_state == ST_DONE) req_done[r_grant_idx] = 1'b1;
  end

endmodule

`default_nettype wire

// File: tb/tb_axilite_bk_arbiter.sv
// ============================================================================
// tb_axilite_bk_arbiter : directed bench with a transaction-level reference model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_axilite_bk_arbiter;

  localparam int N = 4;

  logic            axi_aclk = 1'b0;
  logic            axi_aresetn = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    req_wr = '0;
  logic [N*32-1:0] req_addr = '0;
  logic [N*32-1:0] req_wdata = '0;
  logic [N*4-1:0]  req_wstrb = '0;
  logic [N-1:0]    req_done;
  logic [31:0]     req_rdata;
  logic            busy;
  logic            bk_wstart;
  logic [31:0]     bk_waddr;
  logic [31:0]     bk_wdata;
  logic [3:0]      bk_wstrb;
  logic            bk_rstart;
  logic [31:0]     bk_raddr;
  logic            bk_wdone = 1'b0;
  logic            bk_rdone = 1'b0;
  logic [31:0]     bk_rdata = '0;

  axilite_bk_arbiter #(.NUM_REQ(N)) dut (
    .axi_aclk    (axi_aclk),
    .axi_aresetn (axi_aresetn),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_wr      (req_wr),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_wstrb   (req_wstrb),
    .req_done    (req_done),
    .req_rdata   (req_rdata),
    .busy        (busy),
    .bk_wstart   (bk_wstart),
    .bk_waddr    (bk_waddr),
    .bk_wdata    (bk_wdata),
    .bk_wstrb    (bk_wstrb),
    .bk_rstart   (bk_rstart),
    .bk_raddr    (bk_raddr),
    .bk_wdone    (bk_wdone),
    .bk_rdone    (bk_rdone),
    .bk_rdata    (bk_rdata)
  );

  always #5 axi_aclk = ~axi_aclk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: one owner at a time, tracked by age since acceptance.
  int          m_owner = -1;
  int          m_ptr   = 0;
  int          m_age   = 0;
  bit          m_bdone = 1'b0;
  bit          m_wr    = 1'b0;
  logic [31:0] m_addr  = '0;
  logic [31:0] m_wdata = '0;
  logic [3:0]  m_wstrb = '0;
  logic [31:0] m_rdata = '0;
  int          m_pick;
  int          glog[$];

  logic [N-1:0] e_ready, e_done;
  logic [31:0]  e_rdata, e_addr, e_wdata;
  logic [3:0]   e_wstrb;
  logic         e_busy, e_wstart, e_rstart;

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (((v >> ((p + k) % N)) & N'(1)) != '0) return (p + k) % N;
    end
    return -1;
  endfunction

  always @(negedge axi_aclk) begin
    if (!axi_aresetn) begin
      m_owner = -1; m_ptr = 0; m_age = 0; m_bdone = 1'b0; m_rdata = '0;
    end
    m_pick  = pick(req_valid, m_ptr);
    e_ready = (axi_aresetn && m_owner < 0 && m_pick >= 0) ? N'(1) << m_pick : '0;
    e_busy  = (m_owner >= 0);
    e_wstart = (m_owner >= 0) && (m_age == 1) && m_wr;
    e_rstart = (m_owner >= 0) && (m_age == 1) && !m_wr;
    e_addr  = (m_owner >= 0) ? m_addr  : '0;
    e_wdata = (m_owner >= 0) ? m_wdata : '0;
    e_wstrb = (m_owner >= 0) ? m_wstrb : '0;
    e_done  = (m_owner >= 0 && m_bdone) ? N'(1) << m_owner : '0;
    e_rdata = (m_owner >= 0 && m_bdone && !m_wr) ? m_rdata : '0;

    chk("m_ready",  req_ready, e_ready);
    chk("m_busy",   busy,      e_busy);
    chk("m_wstart", bk_wstart, e_wstart);
    chk("m_rstart", bk_rstart, e_rstart);
    chk("m_waddr",  bk_waddr,  e_addr);
    chk("m_raddr",  bk_raddr,  e_addr);
    chk("m_wdata",  bk_wdata,  e_wdata);
    chk("m_wstrb",  bk_wstrb,  e_wstrb);
    chk("m_done",   req_done,  e_done);
    chk("m_rdata",  req_rdata, e_rdata);

    for (int i = 0; i < N; i++)
      if (axi_aresetn && req_ready == (N'(1) << i)) glog.push_back(i);

    if (axi_aresetn) begin
      if (m_owner < 0) begin
        if (m_pick >= 0) begin
          m_owner = m_pick;
          m_wr    = req_wr[m_pick];
          m_addr  = req_addr[32*m_pick +: 32];
          m_wdata = req_wdata[32*m_pick +: 32];
          m_wstrb = req_wstrb[4*m_pick +: 4];
          m_rdata = '0;
          m_age   = 1;
          m_bdone = 1'b0;
        end
      end else if (m_bdone) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
        m_bdone = 1'b0;
      end else if (m_age == 1) begin
        m_age = 2;
      end else if (m_wr ? bk_wdone : bk_rdone) begin
        m_bdone = 1'b1;
        if (!m_wr) m_rdata = bk_rdata;
      end
    end
  end

  task automatic tick();
    @(posedge axi_aclk);
    #1;
  endtask

  task automatic set_req(input int i, input bit wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
    req_wr[i]            = wr;
    req_addr[32*i +: 32] = a;
    req_wdata[32*i +: 32] = d;
    req_wstrb[4*i +: 4]  = s;
  endtask

  // Returns at the negedge of the cycle in which a start pulse is seen.
  task automatic wait_start(output bit is_wr);
    bit found;
    found = 1'b0;
    is_wr = 1'b0;
    for (int c = 0; c < 50 && !found; c++) begin
      @(negedge axi_aclk);
      if (bk_wstart || bk_rstart) begin
        found = 1'b1;
        is_wr = bk_wstart;
      end else begin
        @(posedge axi_aclk);
        #1;
      end
    end
    if (!found) chk("start_timeout", 64'd0, 64'd1);
  endtask

  // Called one cycle after the start; returns just after the edge entering the done cycle.
  task automatic respond(input bit is_wr, input int lat, input logic [31:0] rd);
    repeat (lat) tick();
    if (is_wr) bk_wdone = 1'b1;
    else begin
      bk_rdone = 1'b1;
      bk_rdata = rd;
    end
    tick();
    bk_wdone = 1'b0;
    bk_rdone = 1'b0;
    bk_rdata = '0;
  endtask

  initial begin
    bit w;
    int exp_order [8] = '{0, 1, 2, 3, 0, 1, 2, 3};

    repeat (3) tick();
    @(negedge axi_aclk);
    chk("reset_busy",  busy,      64'd0);
    chk("reset_ready", req_ready, 64'd0);
    tick();
    axi_aresetn = 1'b1;
    tick();

    // All requesters continuously valid: strict rotation.
    for (int i = 0; i < N; i++)
      set_req(i, i[0], 32'h1000_0000 + 32'(i * 16), 32'hA5A5_0000 + 32'(i), 4'(1 << i));
    glog.delete();
    req_valid = '1;
    for (int t = 0; t < 8; t++) begin
      wait_start(w);
      chk("rot_addr", bk_waddr, 64'(32'h1000_0000 + 32'(exp_order[t] * 16)));
      chk("rot_kind", w, 64'(exp_order[t] % 2));
      tick();
      if (t == 7) req_valid = '0;
      respond(w, t % 3, 32'hB000_0000 + 32'(t));
    end
    tick();
    chk("rot_count", glog.size(), 64'd8);
    for (int t = 0; t < 8 && t < glog.size(); t++) chk("rot_order", glog[t], exp_order[t]);

    // Single write from requester 2.
    set_req(2, 1'b1, 32'h3000_0010, 32'hDEAD_BEEF, 4'hF);
    req_valid = 4'b0100;
    @(negedge axi_aclk);
    chk("wr_ready", req_ready, 64'h4);
    tick();
    req_valid = '0;
    wait_start(w);
    chk("wr_wstart", bk_wstart, 64'd1);
    chk("wr_rstart", bk_rstart, 64'd0);
    chk("wr_waddr",  bk_waddr,  64'h3000_0010);
    chk("wr_wdata",  bk_wdata,  64'hDEAD_BEEF);
    chk("wr_wstrb",  bk_wstrb,  64'hF);
    tick();
    respond(1'b1, 1, 32'h0);
    @(negedge axi_aclk);
    chk("wr_done", req_done, 64'h4);
    chk("wr_rdata", req_rdata, 64'h0);
    tick();
    @(negedge axi_aclk);
    chk("wr_done_off", req_done, 64'h0);
    chk("wr_idle", busy, 64'd0);
    tick();

    // Single read from requester 0.
    set_req(0, 1'b0, 32'h3000_0004, 32'h0, 4'h0);
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    wait_start(w);
    chk("rd_rstart", bk_rstart, 64'd1);
    chk("rd_raddr",  bk_raddr,  64'h3000_0004);
    tick();
    respond(1'b0, 0, 32'h1234_5678);
    @(negedge axi_aclk);
    chk("rd_done",  req_done,  64'h1);
    chk("rd_rdata", req_rdata, 64'h1234_5678);
    tick();

    // Stray rdone during a write, then wdone while idle.
    set_req(1, 1'b1, 32'h2000_0000, 32'h5555_AAAA, 4'h3);
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    wait_start(w);
    tick();
    bk_rdone = 1'b1;
    bk_rdata = 32'hFFFF_FFFF;
    tick();
    bk_rdone = 1'b0;
    bk_rdata = '0;
    @(negedge axi_aclk);
    chk("stray_busy", busy, 64'd1);
    chk("stray_done", req_done, 64'h0);
    tick();
    respond(1'b1, 0, 32'h0);
    @(negedge axi_aclk);
    chk("stray_wr_done", req_done, 64'h2);
    tick();
    bk_wdone = 1'b1;
    tick();
    bk_wdone = 1'b0;
    @(negedge axi_aclk);
    chk("idle_wdone_busy", busy, 64'd0);
    chk("idle_wdone_done", req_done, 64'h0);
    tick();

    // Reset while waiting on a read from requester 3.
    set_req(3, 1'b0, 32'h4000_0000, 32'h0, 4'h0);
    req_valid = 4'b1000;
    tick();
    req_valid = '0;
    wait_start(w);
    tick();
    tick();
    set_req(1, 1'b0, 32'h5000_0008, 32'h0, 4'h0);
    axi_aresetn = 1'b0;
    req_valid = 4'b1010;
    @(negedge axi_aclk);
    chk("rst_busy",  busy,      64'd0);
    chk("rst_ready", req_ready, 64'h0);
    chk("rst_raddr", bk_raddr,  64'h0);
    chk("rst_done",  req_done,  64'h0);
    tick();
    tick();
    axi_aresetn = 1'b1;
    @(negedge axi_aclk);
    chk("post_rst_ready", req_ready, 64'h2);
    tick();
    req_valid = '0;
    wait_start(w);
    chk("post_rst_raddr", bk_raddr, 64'h5000_0008);
    tick();
    respond(1'b0, 2, 32'hCAFE_F00D);
    @(negedge axi_aclk);
    chk("post_rst_done",  req_done,  64'h2);
    chk("post_rst_rdata", req_rdata, 64'hCAFE_F00D);
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
